// File: rtl/cyx_fetch_if.sv
// rtl/cyx_fetch_if.sv - fetch unit ROM, decode and redirect signal bundle
interface cyx_fetch_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      rom_adr;
  logic [31:0]      rom_dout;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic [31:0]      if_pc4;
  logic             id_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_target;
  logic             align_err;
  logic [CNT_W-1:0] fetch_cnt;

  // fetch unit side
  modport master (
    output rom_adr,
    input  rom_dout,
    output if_valid,
    output if_instr,
    output if_pc,
    output if_pc4,
    input  id_ready,
    input  redirect_valid,
    input  redirect_target,
    output align_err,
    output fetch_cnt
  );

  // ROM / decode / execute side
  modport slave (
    input  rom_adr,
    output rom_dout,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_pc4,
    output id_ready,
    output redirect_valid,
    output redirect_target,
    input  align_err,
    input  fetch_cnt
  );
endinterface

// File: rtl/cyx_fetch_unit.sv
// rtl/cyx_fetch_unit.sv - instruction fetch stage with PC, output register and redirect
module cyx_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic         clk,
  input logic         rst_n,
  cyx_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pc;
  logic             r_if_valid;
  logic [31:0]      r_if_instr;
  logic [31:0]      r_if_pc;
  logic [31:0]      r_if_pc4;
  logic             r_align_err;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             w_load;
  logic             w_xfer;
  logic [31:0]      w_pc4;

  assign w_pc4 = r_pc + 32'd4;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // next state: redirect always lands in RUN; HOLD tracks a stalled valid output
  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: w_state_nxt = ST_RUN;
        ST_RUN:  if (r_if_valid && !bus.id_ready) w_state_nxt = ST_HOLD;
        ST_HOLD: if (bus.id_ready) w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  // outputs of the FSM: load when the output register is free, never during a redirect
  always_comb begin
    w_load = (r_state != ST_BOOT) && (!r_if_valid || bus.id_ready) && !bus.redirect_valid;
    w_xfer = r_if_valid && bus.id_ready;
  end

  // PC: redirect wins over sequential advance; frozen otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_pc <= RESET_PC;
    else if (bus.redirect_valid) r_pc <= {bus.redirect_target[31:2], 2'b00};
    else if (w_load)             r_pc <= w_pc4;
  end

  // output register: redirect only drops valid, data stays stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_instr <= 32'd0;
      r_if_pc    <= 32'd0;
      r_if_pc4   <= 32'd0;
    end else if (bus.redirect_valid) begin
      r_if_valid <= 1'b0;
    end else if (w_load) begin
      r_if_valid <= 1'b1;
      r_if_instr <= bus.rom_dout;
      r_if_pc    <= r_pc;
      r_if_pc4   <= w_pc4;
    end
  end

  // sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                 r_align_err <= 1'b0;
    else if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00)) r_align_err <= 1'b1;
  end

  // transfer counter; a redirect in the same cycle does not cancel the transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_fetch_cnt <= '0;
    else if (w_xfer) r_fetch_cnt <= r_fetch_cnt + 1'b1;
  end

  assign bus.rom_adr   = r_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_instr  = r_if_instr;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_pc4    = r_if_pc4;
  assign bus.align_err = r_align_err;
  assign bus.fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_cyx_fetch_unit.sv
// tb/tb_cyx_fetch_unit.sv - scoreboard testbench for cyx_fetch_unit
module tb_cyx_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  cyx_fetch_if #(.CNT_W(32)) bus ();

  cyx_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    case (a)
      32'h00: rom_fn = 32'h8c22_0000;
      32'h04: rom_fn = 32'h8c23_0004;
      32'h08: rom_fn = 32'h8c24_0008;
      32'h0C: rom_fn = 32'h0046_3020;
      32'h10: rom_fn = 32'h0085_3822;
      32'h14: rom_fn = 32'h00e4_4024;
      32'h18: rom_fn = 32'h0107_4825;
      32'h1C: rom_fn = 32'h0128_502a;
      32'h20: rom_fn = 32'hac2a_000c;
      32'h24: rom_fn = 32'h1000_fff6;
      32'h28: rom_fn = 32'h2129_0001;
      32'h2C: rom_fn = 32'h0800_0002;
      default: rom_fn = 32'h0000_0000;
    endcase
  endfunction

  always_comb bus.rom_dout = rom_fn(bus.rom_adr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: every transfer presented to decode must match the next expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.if_valid === 1'b1 && bus.id_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: transfer pc %h instr %h with empty queue", bus.if_pc, bus.if_instr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", bus.if_instr, e.instr);
          chk("sb_pc", bus.if_pc, e.pc);
          chk("sb_pc4", bus.if_pc4, e.pc + 32'd4);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst_n               = 1'b0;
    bus.id_ready        = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    #12;
    rst_n = 1'b1;
    #1;
    chk("rst_rom_adr", bus.rom_adr, 32'h0);
    chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_fetch_cnt", bus.fetch_cnt, 32'd0);
    chk("rst_align_err", {31'd0, bus.align_err}, 32'd0);

    push_exp(32'h0, 32'h8c22_0000);
    push_exp(32'h4, 32'h8c23_0004);
    push_exp(32'h8, 32'h8c24_0008);

    step();
    chk("boot_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("boot_rom_adr", bus.rom_adr, 32'h0);
    step();
    chk("c1_if_instr", bus.if_instr, 32'h8c22_0000);
    chk("c1_if_pc", bus.if_pc, 32'h0);
    chk("c1_if_pc4", bus.if_pc4, 32'h4);
    chk("c1_rom_adr", bus.rom_adr, 32'h4);
    step();
    chk("c2_if_instr", bus.if_instr, 32'h8c23_0004);
    chk("c2_if_pc", bus.if_pc, 32'h4);
    step();
    chk("c3_if_pc", bus.if_pc, 32'h8);
    bus.id_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_if_pc", bus.if_pc, 32'h8);
      chk("hold_if_instr", bus.if_instr, 32'h8c24_0008);
      chk("hold_rom_adr", bus.rom_adr, 32'hC);
      chk("hold_fetch_cnt", bus.fetch_cnt, 32'd2);
      chk("hold_if_valid", {31'd0, bus.if_valid}, 32'd1);
    end

    for (logic [31:0] a = 32'hC; a <= 32'h2C; a += 32'h4) push_exp(a, rom_fn(a));
    bus.id_ready = 1'b1;
    step();
    chk("rel_if_instr", bus.if_instr, 32'h0046_3020);
    chk("rel_if_pc", bus.if_pc, 32'hC);
    chk("rel_fetch_cnt", bus.fetch_cnt, 32'd3);
    repeat (8) step();
    chk("pre_redir_if_pc", bus.if_pc, 32'h2C);

    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h8;
    step();
    bus.redirect_valid = 1'b0;
    chk("redir_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("redir_rom_adr", bus.rom_adr, 32'h8);
    chk("redir_fetch_cnt", bus.fetch_cnt, 32'd12);
    push_exp(32'h8, 32'h8c24_0008);
    push_exp(32'hC, 32'h0046_3020);
    step();
    chk("post_redir_if_instr", bus.if_instr, 32'h8c24_0008);
    chk("post_redir_if_pc", bus.if_pc, 32'h8);
    chk("post_redir_fetch_cnt", bus.fetch_cnt, 32'd12);
    step();

    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h2D;
    step();
    chk("mis_rom_adr", bus.rom_adr, 32'h2C);
    chk("mis_align_err", {31'd0, bus.align_err}, 32'd1);
    chk("mis_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("mis_fetch_cnt", bus.fetch_cnt, 32'd14);
    bus.redirect_target = 32'h10;
    step();
    chk("al_rom_adr", bus.rom_adr, 32'h10);
    chk("al_align_err", {31'd0, bus.align_err}, 32'd1);
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    chk("top_rom_adr", bus.rom_adr, 32'hFFFF_FFFC);
    chk("top_align_err", {31'd0, bus.align_err}, 32'd1);
    push_exp(32'hFFFF_FFFC, 32'h0);
    push_exp(32'h0, 32'h8c22_0000);
    step();
    chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_pc4", bus.if_pc4, 32'h0);
    chk("wrap_if_instr", bus.if_instr, 32'h0);
    chk("wrap_rom_adr", bus.rom_adr, 32'h0);
    step();
    chk("wrap2_if_instr", bus.if_instr, 32'h8c22_0000);
    chk("wrap2_if_pc", bus.if_pc, 32'h0);
    step();
    chk("pre_rst_fetch_cnt", bus.fetch_cnt, 32'd16);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("arst_if_instr", bus.if_instr, 32'h0);
    chk("arst_if_pc", bus.if_pc, 32'h0);
    chk("arst_if_pc4", bus.if_pc4, 32'h0);
    chk("arst_rom_adr", bus.rom_adr, 32'h0);
    chk("arst_fetch_cnt", bus.fetch_cnt, 32'd0);
    chk("arst_align_err", {31'd0, bus.align_err}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    push_exp(32'h0, 32'h8c22_0000);
    step();
    chk("reboot_if_valid", {31'd0, bus.if_valid}, 32'd0);
    step();
    chk("reboot_if_instr", bus.if_instr, 32'h8c22_0000);
    chk("reboot_if_pc", bus.if_pc, 32'h0);
    step();
    bus.id_ready = 1'b0;
    chk("reboot_fetch_cnt", bus.fetch_cnt, 32'd1);
    @(negedge clk);
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
